pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL expose parameter DATA_W, default 128, width of the opaque payload bus.
REQ-002 SHALL expose parameter TNEW_W, default 2, width of the Tnew field.
REQ-003 SHALL expose parameter EXC_W, default 5, width of the exception-code field.
REQ-004 SHALL expose parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-005 SHALL expose parameter DEC_TNEW, default 1: 1 = saturating Tnew decrement on load, 0 = Tnew passes through unchanged.
REQ-006 clk  in  1  clock; all state updates on posedge clk.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 stall_i  in  1  hold the current contents.
REQ-009 flush_i  in  1  replace the incoming instruction with a bubble.
REQ-010 valid_i / valid_o  in / out  1  the slot holds a real instruction.
REQ-011 data_i / data_o  in / out  DATA_W  opaque payload (control and operand fields).
REQ-012 pc_i / pc_o  in / out  32  instruction PC.
REQ-013 bd_i / bd_o  in / out  1  branch-delay-slot flag.
REQ-014 tnew_i / tnew_o  in / out  TNEW_W  cycles until the result is produced.
REQ-015 regwrite_i / regwrite_o  in / out  1  GPR write request.
REQ-016 wreg_i / wreg_o  in / out  5  destination GPR.
REQ-017 exc_i / exc_o  in / out  EXC_W  exception code; 0 = none.
REQ-018 stall_cnt_o  out  CNT_W  count of cycles this stage held a valid instruction under stall.

Function
REQ-019 Each cycle SHALL apply exactly one action, in priority order: rst > flush_i > stall_i > load.
REQ-020 Load SHALL register every *_i field into its *_o counterpart, subject to REQ-023 to REQ-025.
REQ-021 Stall SHALL hold every output unchanged, including tnew_o (no decrement while held).
REQ-022 Flush SHALL load pc_i and bd_i, and SHALL set valid_o=0, data_o=0, tnew_o=0, regwrite_o=0, wreg_o=0 and exc_o=0, so a bubble carries a PC for EPC purposes.
REQ-023 On load with DEC_TNEW=1, tnew_o SHALL be (tnew_i==0) ? 0 : tnew_i-1; it SHALL never wrap.
REQ-024 On load, regwrite_o SHALL be regwrite_i & valid_i & (wreg_i!=0) & (exc_i==0).
REQ-025 On load with valid_i=0, the result SHALL equal the flush action: bubble contents, with pc_i and bd_i kept.
REQ-026 On load, wreg_o SHALL be 0 whenever regwrite_o is 0.
REQ-027 stall_cnt_o SHALL increment by 1 on each cycle with stall_i=1, flush_i=0 and valid_o=1.
REQ-028 stall_cnt_o SHALL saturate at 2^CNT_W-1, with no wrap.
REQ-029 stall_cnt_o SHALL be cleared only by rst; flush SHALL NOT clear it.
REQ-030 When stall_i and flush_i are asserted together, flush SHALL win and the counter SHALL NOT increment.
REQ-031 Outputs SHALL be registered only, with no combinational path from any input to any output.
REQ-032 Latency SHALL be 1 cycle from input to output on load.

Reset
REQ-033 In any cycle with rst=1, all outputs, including pc_o, bd_o and stall_cnt_o, SHALL be 0 at the next edge, regardless of stall_i and flush_i.
REQ-034 Asserting rst mid-stall SHALL discard the held instruction.
REQ-035 The first cycle after rst deasserts SHALL behave as a normal load/stall/flush cycle.

Verification
REQ-036 Load: valid_i=1, tnew_i=2, regwrite_i=1, wreg_i=8, exc_i=0 -> next cycle tnew_o=1, regwrite_o=1, wreg_o=8, valid_o=1.
REQ-037 Saturation: tnew_i=0 loaded -> tnew_o=0; with DEC_TNEW=0, tnew_i=3 -> tnew_o=3.
REQ-038 Gating: wreg_i=0 with regwrite_i=1 -> regwrite_o=0; exc_i=4 (AdEL) with wreg_i=5 -> regwrite_o=0, wreg_o=0, exc_o=4.
REQ-039 Stall and flush: hold a valid instruction with stall_i for 3 cycles -> outputs constant and stall_cnt_o +3; then assert stall_i+flush_i with pc_i=0x3008, bd_i=1 -> valid_o=0, pc_o=0x3008, bd_o=1, counter unchanged.
REQ-040 Counter saturation: CNT_W=2, stall 5 cycles with valid_o=1 -> stall_cnt_o reads 1, 2, 3, 3, 3.
REQ-041 Reset priority: rst=1 with stall_i=1 and flush_i=1 -> all outputs 0 next cycle; a load on the following cycle propagates normally.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with stall, flush and bubble insertion.
// Tracks Tnew, gates GPR writes and counts stalled cycles.
module pipe_stage_reg #(
    parameter int DATA_W   = 128,
    parameter int TNEW_W   = 2,
    parameter int EXC_W    = 5,
    parameter int CNT_W    = 16,
    parameter int DEC_TNEW = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [31:0]       pc_i,
    input  logic              bd_i,
    input  logic [TNEW_W-1:0] tnew_i,
    input  logic              regwrite_i,
    input  logic [4:0]        wreg_i,
    input  logic [EXC_W-1:0]  exc_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [31:0]       pc_o,
    output logic              bd_o,
    output logic [TNEW_W-1:0] tnew_o,
    output logic              regwrite_o,
    output logic [4:0]        wreg_o,
    output logic [EXC_W-1:0]  exc_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {
        ACT_RST,
        ACT_BUBBLE,
        ACT_HOLD,
        ACT_LOAD
    } act_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    act_t              act;
    logic              load_wr;
    logic [TNEW_W-1:0] tnew_nx;

    // Pick the single action for this cycle; an invalid load is a bubble.
    always_comb begin
        act = ACT_LOAD;
        if (rst)
            act = ACT_RST;
        else if (flush_i)
            act = ACT_BUBBLE;
        else if (stall_i)
            act = ACT_HOLD;
        else if (!valid_i)
            act = ACT_BUBBLE;
    end

    // Write enable only for a real, exception-free write to a nonzero GPR;
    // Tnew counts down one stage without wrapping below zero.
    always_comb begin
        load_wr = regwrite_i & valid_i & (|wreg_i) & ~(|exc_i);
        tnew_nx = tnew_i;
        if (DEC_TNEW != 0 && tnew_i != '0)
            tnew_nx = tnew_i - TNEW_W'(1);
    end

    // Slot contents: reset clears everything, a bubble keeps only PC/BD.
    always_ff @(posedge clk) begin
        unique case (act)
            ACT_RST: begin
                valid_o    <= 1'b0;
                data_o     <= '0;
                pc_o       <= '0;
                bd_o       <= 1'b0;
                tnew_o     <= '0;
                regwrite_o <= 1'b0;
                wreg_o     <= '0;
                exc_o      <= '0;
            end
            ACT_BUBBLE: begin
                valid_o    <= 1'b0;
                data_o     <= '0;
                pc_o       <= pc_i;
                bd_o       <= bd_i;
                tnew_o     <= '0;
                regwrite_o <= 1'b0;
                wreg_o     <= '0;
                exc_o      <= '0;
            end
            ACT_HOLD: begin
                valid_o    <= valid_o;
                data_o     <= data_o;
                pc_o       <= pc_o;
                bd_o       <= bd_o;
                tnew_o     <= tnew_o;
                regwrite_o <= regwrite_o;
                wreg_o     <= wreg_o;
                exc_o      <= exc_o;
            end
            ACT_LOAD: begin
                valid_o    <= 1'b1;
                data_o     <= data_i;
                pc_o       <= pc_i;
                bd_o       <= bd_i;
                tnew_o     <= tnew_nx;
                regwrite_o <= load_wr;
                wreg_o     <= load_wr ? wreg_i : 5'd0;
                exc_o      <= exc_i;
            end
            default: begin
                valid_o    <= 1'b0;
                data_o     <= '0;
                pc_o       <= '0;
                bd_o       <= 1'b0;
                tnew_o     <= '0;
                regwrite_o <= 1'b0;
                wreg_o     <= '0;
                exc_o      <= '0;
            end
        endcase
    end

    // Saturating count of cycles a real instruction sat stalled here.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_o <= '0;
        else if (act == ACT_HOLD && valid_o && stall_cnt_o != CNT_MAX)
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: default instance plus a
// DEC_TNEW=0 / CNT_W=2 instance driven by the same stimulus.
module tb_pipe_stage_reg;

    logic         clk = 1'b0;
    logic         rst, stall, flush, valid_i, bd_i, rw_i;
    logic [127:0] data_i;
    logic [31:0]  pc_i;
    logic [1:0]   tnew_i;
    logic [4:0]   wreg_i, exc_i;

    logic         va, ba, ra, vb, bb, rb;
    logic [127:0] da, db;
    logic [31:0]  pa, pb;
    logic [1:0]   ta, tb;
    logic [4:0]   wa, wb, ea, eb;
    logic [15:0]  ca;
    logic [1:0]   cb;

    int npass = 0;
    int nchk  = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut_a (
        .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
        .valid_i(valid_i), .data_i(data_i), .pc_i(pc_i), .bd_i(bd_i),
        .tnew_i(tnew_i), .regwrite_i(rw_i), .wreg_i(wreg_i), .exc_i(exc_i),
        .valid_o(va), .data_o(da), .pc_o(pa), .bd_o(ba), .tnew_o(ta),
        .regwrite_o(ra), .wreg_o(wa), .exc_o(ea), .stall_cnt_o(ca)
    );

    pipe_stage_reg #(.DEC_TNEW(0), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
        .valid_i(valid_i), .data_i(data_i), .pc_i(pc_i), .bd_i(bd_i),
        .tnew_i(tnew_i), .regwrite_i(rw_i), .wreg_i(wreg_i), .exc_i(exc_i),
        .valid_o(vb), .data_o(db), .pc_o(pb), .bd_o(bb), .tnew_o(tb),
        .regwrite_o(rb), .wreg_o(wb), .exc_o(eb), .stall_cnt_o(cb)
    );

    typedef struct {
        bit           valid;
        logic [127:0] data;
        logic [31:0]  pc;
        bit           bd;
        int           tnew;
        bit           rw;
        int           wreg;
        int           exc;
        int           cnt;
    } slot_t;

    typedef struct {
        slot_t a;
        slot_t b;
    } exp_t;

    exp_t  q[$];
    slot_t ma, mb;

    function automatic logic [191:0] pack(slot_t s);
        return {1'b0, s.valid, s.data, s.pc, s.bd, 2'(s.tnew), s.rw,
                5'(s.wreg), 5'(s.exc), 16'(s.cnt)};
    endfunction

    // Reference behaviour from the stage's rules, using the current inputs.
    function automatic slot_t nxt(slot_t s, bit dec, int cmax);
        slot_t n;
        bit w;
        n = s;
        if (rst) begin
            n.valid = 0; n.data = '0; n.pc = '0; n.bd = 0;
            n.tnew = 0; n.rw = 0; n.wreg = 0; n.exc = 0; n.cnt = 0;
        end else if (flush || (!stall && !valid_i)) begin
            n.valid = 0; n.data = '0; n.pc = pc_i; n.bd = bd_i;
            n.tnew = 0; n.rw = 0; n.wreg = 0; n.exc = 0;
        end else if (stall) begin
            if (s.valid && s.cnt < cmax) n.cnt = s.cnt + 1;
        end else begin
            w = rw_i && wreg_i != 0 && exc_i == 0;
            n.valid = 1;
            n.data  = data_i;
            n.pc    = pc_i;
            n.bd    = bd_i;
            n.tnew  = dec ? ((tnew_i == 0) ? 0 : int'(tnew_i) - 1)
                          : int'(tnew_i);
            n.rw    = w;
            n.wreg  = w ? int'(wreg_i) : 0;
            n.exc   = int'(exc_i);
        end
        return n;
    endfunction

    task automatic chk(string name, logic [191:0] act, logic [191:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Issue one cycle of the current inputs and queue the expected result.
    task automatic step();
        exp_t e;
        ma = nxt(ma, 1'b1, 65535);
        mb = nxt(mb, 1'b0, 3);
        e.a = ma;
        e.b = mb;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic ld(bit v, int tn, bit r, int w, int ex,
                      logic [31:0] pc, bit b);
        rst = 0; stall = 0; flush = 0;
        valid_i = v; tnew_i = 2'(tn); rw_i = r;
        wreg_i = 5'(w); exc_i = 5'(ex); pc_i = pc; bd_i = b;
        data_i = {$urandom, $urandom, $urandom, $urandom};
        step();
    endtask

    task automatic scramble();
        valid_i = 1'($urandom); rw_i = 1'($urandom);
        tnew_i = 2'($urandom); wreg_i = 5'($urandom);
        exc_i = 5'($urandom); bd_i = 1'($urandom); pc_i = $urandom;
        data_i = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Monitor: every edge after stimulus starts yields one registered result.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("slot_a", {1'b0, va, da, pa, ba, ta, ra, wa, ea, ca},
                    pack(e.a));
                chk("slot_b", {1'b0, vb, db, pb, bb, tb, rb, wb, eb,
                    14'd0, cb}, pack(e.b));
            end
        end
    end

    initial begin
        int exp_c[5];
        exp_c = '{1, 2, 3, 3, 3};
        rst = 1; stall = 0; flush = 0;
        valid_i = 0; rw_i = 0; tnew_i = 0; wreg_i = 0; exc_i = 0;
        bd_i = 0; pc_i = 32'h0; data_i = '0;
        @(negedge clk);
        step();
        chk("reset_state", 192'({va, pa, ba, ca, cb}), 192'(0));

        ld(1, 2, 1, 8, 0, 32'h1000, 0);
        chk("load_basic", 192'({va, ta, ra, wa}), 192'({1'b1, 2'd1, 1'b1, 5'd8}));
        ld(1, 0, 1, 3, 0, 32'h1004, 0);
        chk("tnew_sat0", 192'(ta), 192'(0));
        ld(1, 3, 1, 3, 0, 32'h1008, 0);
        chk("tnew_nodec", 192'({ta, tb}), 192'({2'd2, 2'd3}));
        ld(1, 1, 1, 0, 0, 32'h100c, 0);
        chk("gate_r0", 192'(ra), 192'(0));
        ld(1, 1, 1, 5, 4, 32'h1010, 0);
        chk("gate_exc", 192'({ra, wa, ea}), 192'({1'b0, 5'd0, 5'd4}));

        ld(1, 2, 1, 9, 0, 32'h3004, 0);
        stall = 1;
        repeat (3) begin
            scramble();
            step();
        end
        chk("stall_hold", 192'({va, pa, ta, wa, ca}),
            192'({1'b1, 32'h3004, 2'd1, 5'd9, 16'd3}));
        stall = 1; flush = 1; pc_i = 32'h3008; bd_i = 1; valid_i = 1;
        step();
        chk("stall_flush", 192'({va, pa, ba, ca, ra}),
            192'({1'b0, 32'h3008, 1'b1, 16'd3, 1'b0}));

        rst = 1; flush = 0; stall = 0;
        step();
        ld(1, 1, 1, 2, 0, 32'h2000, 0);
        stall = 1;
        for (int i = 0; i < 5; i++) begin
            scramble();
            step();
            chk("cnt_sat", 192'(cb), 192'(exp_c[i]));
        end

        rst = 1; stall = 1; flush = 1;
        step();
        chk("rst_prio", 192'({va, pa, ba, ra, wa, ca, cb}), 192'(0));
        ld(1, 3, 1, 7, 0, 32'h4000, 1);
        chk("post_rst_load", 192'({va, pa, ba, wa, ta}),
            192'({1'b1, 32'h4000, 1'b1, 5'd7, 2'd2}));

        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 99) < 2);
            flush = ($urandom_range(0, 99) < 10);
            stall = ($urandom_range(0, 99) < 35);
            scramble();
            valid_i = ($urandom_range(0, 99) < 80);
            wreg_i  = 5'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 31));
            exc_i   = 5'($urandom_range(0, 3) == 0 ? $urandom_range(1, 31) : 0);
            step();
        end

        rst = 0; stall = 0; flush = 0;
        @(negedge clk);
        chk("queue_drained", 192'(q.size()), 192'(0));
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
